// File: rtl/alu_control_md.sv
// alu_control_md: EX-stage ALU control with a multi-cycle multiply/divide sequencer.
//
// Decodes {alu_op, function} into a registered ALU operation code. The code has
// one cycle of latency and is held while the pipeline is stalled. The block also
// sequences MULT/MULTU/DIV/DIVU as IDLE -> RUN (MD_CYCLES cycles) -> DONE, and
// generates the start, busy, done and HI/LO write strobes plus the pipeline stall.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-low reset
//   valid_i         EX stage holds a valid instruction
//   flush_i         synchronous pipeline flush (highest priority)
//   alu_op_i        ALUOp from main control
//   alu_function_i  instruction function field
//   divisor_zero_i  divisor operand is zero (sampled when a DIV is accepted)
//   alu_operation_o registered ALU operation code (zero-extended to OP_WIDTH)
//   md_op_o         latched MD kind: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   md_start_o      one-cycle pulse in the first RUN cycle
//   md_busy_o       sequencer in RUN
//   md_count_o      current iteration index
//   md_done_o       one-cycle completion pulse
//   hilo_we_o       one-cycle HI/LO write enable
//   stall_o         freeze IF/ID/EX
module alu_control_md #(
  parameter  int unsigned OP_WIDTH  = 4,
  parameter  int unsigned MD_CYCLES = 32,
  localparam int unsigned CNT_W     = $clog2(MD_CYCLES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic [2:0]          alu_op_i,
  input  logic [5:0]          alu_function_i,
  input  logic                divisor_zero_i,
  output logic [OP_WIDTH-1:0] alu_operation_o,
  output logic [1:0]          md_op_o,
  output logic                md_start_o,
  output logic                md_busy_o,
  output logic [CNT_W-1:0]    md_count_o,
  output logic                md_done_o,
  output logic                hilo_we_o,
  output logic                stall_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [1:0]            md_op_q, md_op_d;
  logic                  zdiv_q, zdiv_d;
  logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;

  logic [3:0]            dec_code;
  logic                  md_req;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  // Operation-code decode of the instruction currently in EX.
  always_comb begin
    dec_code = 4'd0;
    if (valid_i) begin
      if (alu_op_i == 3'b111) begin
        case (alu_function_i)
          6'b100000: dec_code = 4'd3;
          6'b100010: dec_code = 4'd1;
          6'b100101: dec_code = 4'd2;
          6'b000000: dec_code = 4'd5;
          6'b000010: dec_code = 4'd6;
          6'b100100: dec_code = 4'd7;
          6'b100111: dec_code = 4'd8;
          6'b101010: dec_code = 4'd10;
          6'b100110: dec_code = 4'd11;
          6'b010000: dec_code = 4'd12;
          6'b010010: dec_code = 4'd13;
          6'b011000,
          6'b011001,
          6'b011010,
          6'b011011: dec_code = 4'd14;
          default:   dec_code = 4'd9;
        endcase
      end else begin
        case (alu_op_i)
          3'b000:  dec_code = 4'd1;
          3'b001:  dec_code = 4'd4;
          3'b010:  dec_code = 4'd2;
          3'b011:  dec_code = 4'd7;
          3'b100:  dec_code = 4'd3;
          3'b101:  dec_code = 4'd9;
          3'b110:  dec_code = 4'd10;
          default: dec_code = 4'd9;
        endcase
      end
    end
  end

  assign md_req = valid_i && (alu_op_i == 3'b111) && (alu_function_i[5:2] == 4'b0110);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    md_op_d  = md_op_q;
    zdiv_d   = zdiv_q;
    alu_op_d = (state_q == S_RUN) ? alu_op_q : OP_WIDTH'(dec_code);
    if (flush_i) begin
      alu_op_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (md_req && !flush_i) begin
          md_op_d = alu_function_i[1:0];
          // A zero-divisor divide never runs: it goes straight to DONE with no HI/LO write.
          if (alu_function_i[1] && divisor_zero_i) begin
            state_d = S_DONE;
            zdiv_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            zdiv_d  = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (count_q == CNT_LAST) begin
          state_d = S_DONE;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_DONE: begin
        // The MD instruction still sitting in EX is deliberately not re-accepted here.
        state_d = S_IDLE;
        count_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      md_op_q  <= '0;
      zdiv_q   <= 1'b0;
      alu_op_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      md_op_q  <= md_op_d;
      zdiv_q   <= zdiv_d;
      alu_op_q <= alu_op_d;
    end
  end

  // All strobes derive from registered state only, so stall has no input-to-output path.
  assign alu_operation_o = alu_op_q;
  assign md_op_o         = md_op_q;
  assign md_count_o      = count_q;
  assign stall_o         = (state_q == S_RUN);
  assign md_busy_o       = (state_q == S_RUN);
  assign md_start_o      = (state_q == S_RUN) && (count_q == '0);
  assign md_done_o       = (state_q == S_DONE);
  assign hilo_we_o       = (state_q == S_DONE) && !zdiv_q;

endmodule

// File: tb/tb_alu_control_md.sv
module tb_alu_control_md;

  localparam int unsigned OPW = 4;
  localparam int unsigned MDC = 32;
  localparam int unsigned CW  = $clog2(MDC);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           valid_i = 1'b0;
  logic           flush_i = 1'b0;
  logic [2:0]     alu_op_i = '0;
  logic [5:0]     alu_function_i = '0;
  logic           divisor_zero_i = 1'b0;
  logic [OPW-1:0] alu_operation_o;
  logic [1:0]     md_op_o;
  logic           md_start_o;
  logic           md_busy_o;
  logic [CW-1:0]  md_count_o;
  logic           md_done_o;
  logic           hilo_we_o;
  logic           stall_o;

  alu_control_md #(
    .OP_WIDTH (OPW),
    .MD_CYCLES(MDC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .flush_i        (flush_i),
    .alu_op_i       (alu_op_i),
    .alu_function_i (alu_function_i),
    .divisor_zero_i (divisor_zero_i),
    .alu_operation_o(alu_operation_o),
    .md_op_o        (md_op_o),
    .md_start_o     (md_start_o),
    .md_busy_o      (md_busy_o),
    .md_count_o     (md_count_o),
    .md_done_o      (md_done_o),
    .hilo_we_o      (hilo_we_o),
    .stall_o        (stall_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an accepted MD op is described by the cycle number of its
  // accepting edge; every output is then a function of the offset from it.
  int         cyc = 0;
  int         acc = -1;
  bit         acc_zero = 1'b0;
  logic [1:0] m_md_op = '0;
  logic [3:0] m_alu = '0;

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [5:0] fn;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] ref_decode(input logic v, input logic [2:0] op, input logic [5:0] fn);
    if (!v) return 4'd0;
    if (op != 3'd7) begin
      case (op)
        3'd0: return 4'd1;
        3'd1: return 4'd4;
        3'd2: return 4'd2;
        3'd3: return 4'd7;
        3'd4: return 4'd3;
        3'd5: return 4'd9;
        default: return 4'd10;
      endcase
    end
    case (fn)
      6'h20: return 4'd3;
      6'h22: return 4'd1;
      6'h25: return 4'd2;
      6'h00: return 4'd5;
      6'h02: return 4'd6;
      6'h24: return 4'd7;
      6'h27: return 4'd8;
      6'h2a: return 4'd10;
      6'h26: return 4'd11;
      6'h10: return 4'd12;
      6'h12: return 4'd13;
      6'h18, 6'h19, 6'h1a, 6'h1b: return 4'd14;
      default: return 4'd9;
    endcase
  endfunction

  function automatic bit m_active();
    int k;
    if (acc < 0) return 1'b0;
    k = cyc - acc;
    return (k >= 1) && (k <= (acc_zero ? 1 : int'(MDC) + 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_model();
    int k;
    bit st, bz, dn, hw;
    int cnt;
    k = (acc >= 0) ? (cyc - acc) : -1;
    if (acc_zero) begin
      st = 0; bz = 0; cnt = 0; dn = (k == 1); hw = 0;
    end else begin
      st  = (k == 1);
      bz  = (k >= 1) && (k <= int'(MDC));
      cnt = bz ? k - 1 : 0;
      dn  = (k == int'(MDC) + 1);
      hw  = dn;
    end
    chk("alu_operation", 32'(alu_operation_o), 32'(m_alu));
    chk("md_op", 32'(md_op_o), 32'(m_md_op));
    chk("md_start", 32'(md_start_o), 32'(st));
    chk("md_busy", 32'(md_busy_o), 32'(bz));
    chk("stall", 32'(stall_o), 32'(bz));
    chk("md_count", 32'(md_count_o), 32'(cnt));
    chk("md_done", 32'(md_done_o), 32'(dn));
    chk("hilo_we", 32'(hilo_we_o), 32'(hw));
  endtask

  task automatic model_edge();
    int kp;
    bit act, stalled;
    act     = m_active();
    kp      = cyc - acc;
    stalled = act && !acc_zero && (kp <= int'(MDC));
    if (flush_i) m_alu = 4'd0;
    else if (!stalled) m_alu = ref_decode(valid_i, alu_op_i, alu_function_i);
    if (flush_i && act) begin
      acc = -1;
    end else if (!act && valid_i && alu_op_i == 3'd7 && alu_function_i[5:2] == 4'b0110 && !flush_i) begin
      acc      = cyc;
      acc_zero = alu_function_i[1] && divisor_zero_i;
      m_md_op  = alu_function_i[1:0];
    end
    cyc++;
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [5:0] fn,
                      input logic fl, input logic dz);
    valid_i        = v;
    alu_op_i       = op;
    alu_function_i = fn;
    flush_i        = fl;
    divisor_zero_i = dz;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drain();
    for (int g = 0; g < 100 && m_active(); g++) step(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);
    chk("drain_idle", 32'(m_active()), 32'd0);
  endtask

  task automatic model_reset();
    acc     = -1;
    m_alu   = '0;
    m_md_op = '0;
  endtask

  logic [5:0] fpool [0:15];

  initial begin
    int nstall, start_at, done_at, nstarts, done1, start2;
    fpool = '{6'h20, 6'h22, 6'h25, 6'h00, 6'h02, 6'h24, 6'h27, 6'h2a,
              6'h26, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h08};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_model();
    reset = 1'b1;

    // 1. Decode sweep
    vecs.push_back('{1'b1, 3'd7, 6'h20, 4'd3});
    vecs.push_back('{1'b1, 3'd7, 6'h22, 4'd1});
    vecs.push_back('{1'b1, 3'd7, 6'h25, 4'd2});
    vecs.push_back('{1'b1, 3'd7, 6'h00, 4'd5});
    vecs.push_back('{1'b1, 3'd7, 6'h02, 4'd6});
    vecs.push_back('{1'b1, 3'd7, 6'h24, 4'd7});
    vecs.push_back('{1'b1, 3'd7, 6'h27, 4'd8});
    vecs.push_back('{1'b1, 3'd7, 6'h2a, 4'd10});
    vecs.push_back('{1'b1, 3'd7, 6'h26, 4'd11});
    vecs.push_back('{1'b1, 3'd7, 6'h10, 4'd12});
    vecs.push_back('{1'b1, 3'd7, 6'h12, 4'd13});
    vecs.push_back('{1'b1, 3'd7, 6'h18, 4'd14});
    vecs.push_back('{1'b1, 3'd7, 6'h19, 4'd14});
    vecs.push_back('{1'b1, 3'd7, 6'h1a, 4'd14});
    vecs.push_back('{1'b1, 3'd7, 6'h1b, 4'd14});
    vecs.push_back('{1'b1, 3'd0, 6'h2a, 4'd1});
    vecs.push_back('{1'b1, 3'd1, 6'h15, 4'd4});
    vecs.push_back('{1'b1, 3'd2, 6'h00, 4'd2});
    vecs.push_back('{1'b1, 3'd3, 6'h3f, 4'd7});
    vecs.push_back('{1'b1, 3'd4, 6'h20, 4'd3});
    vecs.push_back('{1'b1, 3'd5, 6'h01, 4'd9});
    vecs.push_back('{1'b1, 3'd6, 6'h11, 4'd10});
    vecs.push_back('{1'b0, 3'd7, 6'h20, 4'd0});
    vecs.push_back('{1'b1, 3'd7, 6'h08, 4'd9});
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].op, vecs[i].fn, 1'b0, 1'b0);
      chk("dec_table", 32'(alu_operation_o), 32'(vecs[i].exp));
      drain();
    end

    // 2. MULT timing
    step(1'b1, 3'd7, 6'h18, 1'b0, 1'b0);
    nstall = 0; start_at = -1; done_at = -1;
    for (int i = 1; i <= 34; i++) begin
      if (i > 1) step(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);
      if (stall_o) nstall++;
      if (md_start_o) start_at = i;
      if (md_done_o && hilo_we_o && !stall_o) done_at = i;
    end
    chk("t2_start_offset", 32'(start_at), 32'd1);
    chk("t2_stall_cycles", 32'(nstall), 32'd32);
    chk("t2_done_offset", 32'(done_at), 32'd33);

    // 3. DIVU with zero divisor
    step(1'b1, 3'd7, 6'h1b, 1'b0, 1'b1);
    chk("t3_done", 32'(md_done_o), 32'd1);
    chk("t3_hilo", 32'(hilo_we_o), 32'd0);
    chk("t3_start", 32'(md_start_o), 32'd0);
    chk("t3_stall", 32'(stall_o), 32'd0);
    chk("t3_md_op", 32'(md_op_o), 32'd3);
    step(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);
    drain();

    // 4. MULTU held in EX: back-to-back acceptances
    nstarts = 0; done1 = -1; start2 = -1;
    for (int i = 1; i <= 75; i++) begin
      step(1'b1, 3'd7, 6'h19, 1'b0, 1'b0);
      if (md_start_o) begin
        nstarts++;
        if (nstarts == 2) start2 = i;
      end
      if (md_done_o && done1 < 0) done1 = i;
    end
    chk("t4_starts", 32'(nstarts), 32'd3);
    chk("t4_restart_gap", 32'(start2 - done1), 32'd2);
    drain();

    // 5. Flush at count 10
    step(1'b1, 3'd7, 6'h18, 1'b0, 1'b0);
    for (int g = 0; g < 20 && (cyc - acc) < 11; g++) step(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);
    chk("t5_count_at_flush", 32'(md_count_o), 32'd10);
    step(1'b1, 3'd7, 6'h20, 1'b1, 1'b0);
    chk("t5_alu_zero", 32'(alu_operation_o), 32'd0);
    chk("t5_stall", 32'(stall_o), 32'd0);
    chk("t5_done", 32'(md_done_o | hilo_we_o), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 3'd0, 6'h00, 1'b0, 1'b0);
      chk("t5_no_done", 32'(md_done_o | hilo_we_o), 32'd0);
    end

    // 6. Asynchronous reset mid-RUN
    step(1'b1, 3'd7, 6'h1a, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 3'd7, 6'h1a, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_alu", 32'(alu_operation_o), 32'd0);
    chk("t6_rst_mdop", 32'(md_op_o), 32'd0);
    chk("t6_rst_busy", 32'(md_busy_o | stall_o | md_start_o), 32'd0);
    chk("t6_rst_count", 32'(md_count_o), 32'd0);
    chk("t6_rst_done", 32'(md_done_o | hilo_we_o), 32'd0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    step(1'b1, 3'd7, 6'h1a, 1'b0, 1'b0);
    chk("t6_div_start", 32'(md_start_o), 32'd1);
    chk("t6_div_op", 32'(md_op_o), 32'd2);
    drain();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic v, fl, dz;
      logic [2:0] op;
      logic [5:0] fn;
      v  = ($urandom_range(0, 7) != 0);
      op = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'($urandom_range(0, 7));
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fpool[$urandom_range(0, 15)];
      fl = ($urandom_range(0, 15) == 0);
      dz = 1'($urandom_range(0, 1));
      step(v, op, fn, fl, dz);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
